// File: rtl/proc_pulse_output.sv
// Avalon-MM output port: a WIDTH-bit level register with set/clear access,
// plus timed one-shot inversion pulses, latched completion flags and a maskable irq.
module proc_pulse_output #(
    parameter int WIDTH = 20,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic             irq,
    output logic [WIDTH-1:0] out_port
);

    localparam logic [2:0] A_DATA      = 3'd0;
    localparam logic [2:0] A_SET       = 3'd1;
    localparam logic [2:0] A_CLR       = 3'd2;
    localparam logic [2:0] A_PULSE_LEN = 3'd3;
    localparam logic [2:0] A_PULSE     = 3'd4;
    localparam logic [2:0] A_DONE      = 3'd5;
    localparam logic [2:0] A_IRQ_MASK  = 3'd6;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t             state;
    logic [WIDTH-1:0]   data_reg;
    logic [WIDTH-1:0]   active;
    logic [WIDTH-1:0]   done;
    logic [WIDTH-1:0]   irq_mask;
    logic [CNT_W-1:0]   pulse_len;
    logic [CNT_W-1:0]   cnt;

    logic               wr;
    logic [WIDTH-1:0]   wd_w;
    logic [CNT_W-1:0]   wd_c;
    logic [CNT_W-1:0]   len_eff;
    logic               trigger;
    logic               expire;
    logic [WIDTH-1:0]   done_clr;
    logic [31:0]        rd_mux;
    logic               unused_wd;

    assign wr       = chipselect & ~write_n;
    assign wd_w     = writedata[WIDTH-1:0];
    assign wd_c     = writedata[CNT_W-1:0];
    assign len_eff  = (pulse_len == '0) ? CNT_W'(1) : pulse_len;
    assign trigger  = wr && (address == A_PULSE) && (wd_w != '0);
    // A retrigger on the final count reloads instead of expiring.
    assign expire   = (state == BUSY) && (cnt == CNT_W'(1)) && !trigger;
    assign done_clr = (wr && (address == A_DONE)) ? wd_w : '0;
    assign irq      = |(done & irq_mask);
    assign unused_wd = &{1'b0, writedata};

    always_comb begin
        rd_mux = '0;
        case (address)
            A_DATA, A_SET, A_CLR: rd_mux = 32'(data_reg);
            A_PULSE_LEN:          rd_mux = 32'(pulse_len);
            A_PULSE:              rd_mux = 32'(active);
            A_DONE:               rd_mux = 32'(done);
            A_IRQ_MASK:           rd_mux = 32'(irq_mask);
            default:              rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            data_reg  <= '0;
            active    <= '0;
            done      <= '0;
            irq_mask  <= '0;
            pulse_len <= CNT_W'(1);
            cnt       <= '0;
            readdata  <= '0;
            out_port  <= '0;
        end else begin
            if (wr) begin
                case (address)
                    A_DATA:      data_reg  <= wd_w;
                    A_SET:       data_reg  <= data_reg | wd_w;
                    A_CLR:       data_reg  <= data_reg & ~wd_w;
                    A_PULSE_LEN: pulse_len <= wd_c;
                    A_IRQ_MASK:  irq_mask  <= wd_w;
                    default:     ;
                endcase
            end

            // Shared down-counter: any trigger reloads and extends every active bit.
            if (trigger) begin
                active <= active | wd_w;
                cnt    <= len_eff;
                state  <= BUSY;
            end else if (state == BUSY) begin
                if (cnt == CNT_W'(1)) begin
                    active <= '0;
                    state  <= IDLE;
                end else begin
                    cnt <= cnt - CNT_W'(1);
                end
            end

            // Expiry set takes priority over a same-cycle write-1-to-clear.
            done     <= (done & ~done_clr) | (expire ? active : '0);
            out_port <= data_reg ^ active;
            readdata <= rd_mux;
        end
    end

endmodule
